// File: rtl/pma_dyn_pkg.sv
// Shared types for the runtime-programmable PMA checker: region payload and reset default.
package pma_dyn_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
    logic        executable;
    logic        read_only;
    logic        idempotent;
  } pma_cfg_t;

  localparam pma_cfg_t PMA_DEFAULT = '{
    base:       32'h0000_0000,
    mask:       32'hFFFF_0000,
    executable: 1'b1,
    read_only:  1'b0,
    idempotent: 1'b1
  };

endpackage

// File: rtl/pma_dyn.sv
// Runtime-programmable PMA checker: priority-encoded lockable regions, per-channel 1-cycle check pipeline.
// Optional first-violation log enabled by defining PMA_VIOLATION_LOG_EN.
module pma_dyn
  import pma_dyn_pkg::*;
#(
  parameter int unsigned                PMA_REGIONS = 4,
  parameter int unsigned                PMA_ALIGN   = 10,
  parameter int unsigned                CHANNELS    = 2,
  parameter logic [CHANNELS-1:0]        FETCH_MASK  = CHANNELS'(2'b01),
  parameter int unsigned                CNT_WIDTH   = 16,
  parameter pma_cfg_t [PMA_REGIONS-1:0] PMA_CFG     = {PMA_REGIONS{PMA_DEFAULT}},
  localparam int unsigned IDX_W = (PMA_REGIONS > 1) ? $clog2(PMA_REGIONS) : 1,
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   s_clk_i,
  input  logic                   s_reset_i,
  input  logic                   s_cfg_we_i,
  input  logic [IDX_W-1:0]       s_cfg_idx_i,
  input  logic [1:0]             s_cfg_sel_i,
  input  logic [31:0]            s_cfg_wdata_i,
  output logic [31:0]            s_cfg_rdata_o,
  input  logic [CHANNELS-1:0]    s_req_valid_i,
  output logic [CHANNELS-1:0]    s_req_ready_o,
  input  logic [CHANNELS*32-1:0] s_req_addr_i,
  input  logic [CHANNELS-1:0]    s_req_write_i,
  output logic [CHANNELS-1:0]    s_rsp_valid_o,
  input  logic [CHANNELS-1:0]    s_rsp_ready_i,
  output logic [CHANNELS-1:0]    s_rsp_violation_o,
  output logic [CHANNELS-1:0]    s_rsp_idempotent_o,
  output logic [CNT_WIDTH-1:0]   s_viol_cnt_o,
  input  logic                   s_viol_cnt_clr_i
`ifdef PMA_VIOLATION_LOG_EN
  ,
  output logic [31:0]            s_viol_addr_o,
  output logic [CH_W-1:0]        s_viol_ch_o,
  output logic                   s_viol_vld_o
`endif
);

  localparam int unsigned          SUM_W      = CNT_WIDTH + $clog2(CHANNELS + 1);
  localparam logic [31:0]          ALIGN_MASK = ~((32'd1 << PMA_ALIGN) - 32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  logic [31:0]            r_base [PMA_REGIONS];
  logic [31:0]            r_mask [PMA_REGIONS];
  logic [PMA_REGIONS-1:0] r_exec, r_ro, r_idem, r_valid, r_lock;
  logic [PMA_REGIONS-1:0] w_idx_dec;

  logic [CHANNELS-1:0]    r_rsp_valid, r_rsp_viol, r_rsp_idem;
  logic [CHANNELS-1:0]    w_acc, w_hit, w_exec, w_ro, w_idem, w_viol;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [SUM_W-1:0]       w_nviol, w_sum;

  // Region index decode; indices beyond PMA_REGIONS select nothing.
  always_comb begin
    w_idx_dec = '0;
    for (int i = 0; i < PMA_REGIONS; i++) w_idx_dec[i] = (s_cfg_idx_i == IDX_W'(i));
  end

  always_comb begin
    s_cfg_rdata_o = '0;
    for (int i = 0; i < PMA_REGIONS; i++) begin
      if (w_idx_dec[i]) begin
        case (s_cfg_sel_i)
          2'd0:    s_cfg_rdata_o = r_base[i];
          2'd1:    s_cfg_rdata_o = r_mask[i];
          2'd2:    s_cfg_rdata_o = {24'd0, r_lock[i], 3'd0, r_valid[i], r_idem[i], r_ro[i], r_exec[i]};
          default: s_cfg_rdata_o = '0;
        endcase
      end
    end
  end

  // Region registers; a locked region ignores every field until reset.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      for (int i = 0; i < PMA_REGIONS; i++) begin
        r_base[i]  <= PMA_CFG[i].base;
        r_mask[i]  <= PMA_CFG[i].mask;
        r_exec[i]  <= PMA_CFG[i].executable;
        r_ro[i]    <= PMA_CFG[i].read_only;
        r_idem[i]  <= PMA_CFG[i].idempotent;
        r_valid[i] <= 1'b1;
        r_lock[i]  <= 1'b0;
      end
    end else if (s_cfg_we_i) begin
      for (int i = 0; i < PMA_REGIONS; i++) begin
        if (w_idx_dec[i] && !r_lock[i]) begin
          case (s_cfg_sel_i)
            2'd0: r_base[i] <= s_cfg_wdata_i;
            2'd1: r_mask[i] <= s_cfg_wdata_i;
            2'd2: begin
              r_exec[i]  <= s_cfg_wdata_i[0];
              r_ro[i]    <= s_cfg_wdata_i[1];
              r_idem[i]  <= s_cfg_wdata_i[2];
              r_valid[i] <= s_cfg_wdata_i[3];
              r_lock[i]  <= s_cfg_wdata_i[7];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Attribute lookup: scanning high to low leaves the lowest-index hit in place.
  always_comb begin
    w_hit  = '0;
    w_exec = '0;
    w_ro   = '0;
    w_idem = '0;
    w_viol = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int i = int'(PMA_REGIONS) - 1; i >= 0; i--) begin
        if (r_valid[i] && ((s_req_addr_i[c*32 +: 32] & r_mask[i] & ALIGN_MASK) ==
                           (r_base[i] & ALIGN_MASK))) begin
          w_hit[c]  = 1'b1;
          w_exec[c] = r_exec[i];
          w_ro[c]   = r_ro[i];
          w_idem[c] = r_idem[i];
        end
      end
      w_viol[c] = !w_hit[c] || (FETCH_MASK[c] ? !w_exec[c] : (s_req_write_i[c] && w_ro[c]));
    end
  end

  assign s_req_ready_o = ~r_rsp_valid | s_rsp_ready_i;
  assign w_acc         = s_req_valid_i & s_req_ready_o;

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      r_rsp_valid <= '0;
      r_rsp_viol  <= '0;
      r_rsp_idem  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_acc[c]) begin
          r_rsp_valid[c] <= 1'b1;
          r_rsp_viol[c]  <= w_viol[c];
          r_rsp_idem[c]  <= w_idem[c];
        end else if (s_rsp_ready_i[c]) begin
          r_rsp_valid[c] <= 1'b0;
        end
      end
    end
  end

  // Violations are counted once, when the response is created.
  always_comb begin
    w_nviol = '0;
    for (int c = 0; c < CHANNELS; c++) w_nviol = w_nviol + SUM_W'(w_acc[c] & w_viol[c]);
    w_sum = SUM_W'(r_cnt) + w_nviol;
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i || s_viol_cnt_clr_i) r_cnt <= '0;
    else if (w_sum > SUM_W'(CNT_MAX))  r_cnt <= CNT_MAX;
    else                               r_cnt <= w_sum[CNT_WIDTH-1:0];
  end

  assign s_rsp_valid_o      = r_rsp_valid;
  assign s_rsp_violation_o  = r_rsp_viol;
  assign s_rsp_idempotent_o = r_rsp_idem;
  assign s_viol_cnt_o       = r_cnt;

`ifdef PMA_VIOLATION_LOG_EN
  logic [31:0]     r_log_addr, w_log_addr;
  logic [CH_W-1:0] r_log_ch, w_log_ch;
  logic            r_log_vld, w_log_any;

  // Lowest violating channel this cycle; captured only while the log is empty.
  always_comb begin
    w_log_any  = |(w_acc & w_viol);
    w_log_ch   = '0;
    w_log_addr = '0;
    for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
      if (w_acc[c] && w_viol[c]) begin
        w_log_ch   = CH_W'(c);
        w_log_addr = s_req_addr_i[c*32 +: 32];
      end
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i || s_viol_cnt_clr_i) begin
      r_log_vld  <= 1'b0;
      r_log_addr <= '0;
      r_log_ch   <= '0;
    end else if (!r_log_vld && w_log_any) begin
      r_log_vld  <= 1'b1;
      r_log_addr <= w_log_addr;
      r_log_ch   <= w_log_ch;
    end
  end

  assign s_viol_addr_o = r_log_addr;
  assign s_viol_ch_o   = r_log_ch;
  assign s_viol_vld_o  = r_log_vld;
`endif

endmodule

// File: tb/tb_pma_dyn.sv
// Scoreboard bench for pma_dyn (CNT_WIDTH=4 so saturation is reachable); log checks under PMA_VIOLATION_LOG_EN.
module tb_pma_dyn;

  localparam int unsigned CW      = 4;
  localparam int          CNT_SAT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic [1:0]  req_valid, req_ready, req_write;
  logic [63:0] req_addr;
  logic [1:0]  rsp_valid, rsp_ready, rsp_viol, rsp_idem;
  logic [CW-1:0] viol_cnt;
  logic        cnt_clr;
`ifdef PMA_VIOLATION_LOG_EN
  logic [31:0] log_addr;
  logic        log_ch;
  logic        log_vld;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] mon_e;

  always #5 clk = ~clk;

  pma_dyn #(.CNT_WIDTH(CW)) dut (
    .s_clk_i            (clk),
    .s_reset_i          (rst),
    .s_cfg_we_i         (cfg_we),
    .s_cfg_idx_i        (cfg_idx),
    .s_cfg_sel_i        (cfg_sel),
    .s_cfg_wdata_i      (cfg_wdata),
    .s_cfg_rdata_o      (cfg_rdata),
    .s_req_valid_i      (req_valid),
    .s_req_ready_o      (req_ready),
    .s_req_addr_i       (req_addr),
    .s_req_write_i      (req_write),
    .s_rsp_valid_o      (rsp_valid),
    .s_rsp_ready_i      (rsp_ready),
    .s_rsp_violation_o  (rsp_viol),
    .s_rsp_idempotent_o (rsp_idem),
    .s_viol_cnt_o       (viol_cnt),
    .s_viol_cnt_clr_i   (cnt_clr)
`ifdef PMA_VIOLATION_LOG_EN
    ,
    .s_viol_addr_o      (log_addr),
    .s_viol_ch_o        (log_ch),
    .s_viol_vld_o       (log_vld)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Responses are compared as they are consumed (inputs are stable at negedge).
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (q0.size() == 0) check_eq("rsp0_unexpected", 32'(q0.size()), 32'd1);
        else begin
          mon_e = q0.pop_front();
          check_eq("rsp0", {30'd0, rsp_viol[0], rsp_idem[0]}, {30'd0, mon_e});
        end
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (q1.size() == 0) check_eq("rsp1_unexpected", 32'(q1.size()), 32'd1);
        else begin
          mon_e = q1.pop_front();
          check_eq("rsp1", {30'd0, rsp_viol[1], rsp_idem[1]}, {30'd0, mon_e});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int ch, input logic [31:0] addr, input logic wr,
                           input logic ev, input logic ei);
    req_valid[ch]          = 1'b1;
    req_addr[ch*32 +: 32]  = addr;
    req_write[ch]          = wr;
    if (ch == 0) q0.push_back({ev, ei});
    else         q1.push_back({ev, ei});
    if (ev) exp_cnt = (exp_cnt >= CNT_SAT) ? CNT_SAT : exp_cnt + 1;
  endtask

  task automatic accept;
    tick;
    req_valid = '0;
    check_eq("viol_cnt", 32'(viol_cnt), 32'(exp_cnt));
  endtask

  task automatic drain;
    tick;
    check_eq("drain", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic send(input int ch, input logic [31:0] addr, input logic wr,
                      input logic ev, input logic ei);
    drive_req(ch, addr, wr, ev, ei);
    accept;
    drain;
  endtask

  task automatic cfg_wr(input logic [1:0] idx, input logic [1:0] sel, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = d;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_rd(input string tag, input logic [1:0] idx, input logic [1:0] sel,
                        input logic [31:0] exp);
    cfg_idx = idx; cfg_sel = sel;
    #1;
    check_eq(tag, cfg_rdata, exp);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    exp_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0;
    req_valid = '0; req_write = '0; req_addr = '0; rsp_ready = 2'b11; cnt_clr = 1'b0;
    do_reset;

    // Reset state
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_flags", 32'({rsp_viol, rsp_idem}), 32'd0);
    check_eq("rst_cnt", 32'(viol_cnt), 32'd0);
    cfg_rd("rst_r0_base", 2'd0, 2'd0, 32'h0000_0000);
    cfg_rd("rst_r0_mask", 2'd0, 2'd1, 32'hFFFF_0000);
    cfg_rd("rst_r0_attr", 2'd0, 2'd2, 32'h0000_000D);
    cfg_rd("rst_r0_rsvd", 2'd0, 2'd3, 32'h0000_0000);
`ifdef PMA_VIOLATION_LOG_EN
    check_eq("rst_log_vld", 32'(log_vld), 32'd0);
`endif

    // Basic lookups on both channels
    send(0, 32'h0000_1234, 1'b0, 1'b0, 1'b1);
    send(0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send(1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send(1, 32'h0000_1234, 1'b1, 1'b0, 1'b1);

    // Low PMA_ALIGN address bits are ignored
    cfg_wr(2'd3, 2'd0, 32'h2000_0000);
    cfg_wr(2'd3, 2'd1, 32'hFFFF_FFFF);
    send(0, 32'h2000_03FF, 1'b0, 1'b0, 1'b1);
    send(0, 32'h2000_0400, 1'b0, 1'b1, 1'b0);

    // Priority: region0 shadows the read-only region1 until invalidated
    cfg_wr(2'd1, 2'd0, 32'h0000_1000);
    cfg_wr(2'd1, 2'd1, 32'hFFFF_F000);
    cfg_wr(2'd1, 2'd2, 32'h0000_000A);
    cfg_rd("r1_attr", 2'd1, 2'd2, 32'h0000_000A);
    send(1, 32'h0000_1010, 1'b1, 1'b0, 1'b1);
    cfg_wr(2'd0, 2'd2, 32'h0000_0005);
    send(1, 32'h0000_1010, 1'b1, 1'b1, 1'b0);
    send(1, 32'h0000_1010, 1'b0, 1'b0, 1'b0);
    send(0, 32'h0000_1010, 1'b0, 1'b1, 1'b0);

    // Same-cycle config write: request sees the old configuration
    drive_req(1, 32'h0000_1010, 1'b1, 1'b1, 1'b0);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'd2; cfg_wdata = 32'h0000_000D;
    accept;
    cfg_we = 1'b0;
    drain;
    send(1, 32'h0000_1010, 1'b1, 1'b0, 1'b1);

    // Reserved field select writes nothing
    cfg_wr(2'd0, 2'd3, 32'hFFFF_FFFF);
    cfg_rd("sel3_base", 2'd0, 2'd0, 32'h0000_0000);
    cfg_rd("sel3_mask", 2'd0, 2'd1, 32'hFFFF_0000);
    cfg_rd("sel3_attr", 2'd0, 2'd2, 32'h0000_000D);

    // Lock
    cfg_wr(2'd2, 2'd2, 32'h0000_0088);
    cfg_rd("lock_attr", 2'd2, 2'd2, 32'h0000_0088);
    cfg_wr(2'd2, 2'd0, 32'h4000_0000);
    cfg_rd("lock_base", 2'd2, 2'd0, 32'h0000_0000);
    cfg_wr(2'd2, 2'd2, 32'h0000_000D);
    cfg_rd("lock_attr2", 2'd2, 2'd2, 32'h0000_0088);

    // Reset with a stalled response pending: dropped, regions reload and unlock
    rsp_ready[0] = 1'b0;
    drive_req(0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    accept;
    check_eq("pend_valid", 32'(rsp_valid[0]), 32'd1);
    do_reset;
    rsp_ready = 2'b11;
    check_eq("rst2_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst2_cnt", 32'(viol_cnt), 32'd0);
    cfg_rd("rst2_r2_attr", 2'd2, 2'd2, 32'h0000_000D);
    cfg_rd("rst2_r3_base", 2'd3, 2'd0, 32'h0000_0000);
    cfg_wr(2'd2, 2'd0, 32'h4000_0000);
    cfg_rd("unlock_base", 2'd2, 2'd0, 32'h4000_0000);

    // Backpressure: stable response, no recount, then back-to-back
    rsp_ready[0] = 1'b0;
    drive_req(0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    accept;
    req_valid[0] = 1'b1;
    req_addr[31:0] = 32'h0000_1234;
    req_write[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_valid", 32'(rsp_valid[0]), 32'd1);
      check_eq("stall_flags", 32'({rsp_viol[0], rsp_idem[0]}), 32'd2);
      check_eq("stall_ready", 32'(req_ready[0]), 32'd0);
      check_eq("stall_cnt", 32'(viol_cnt), 32'(exp_cnt));
      tick;
    end
    drive_req(0, 32'h0000_1234, 1'b0, 1'b0, 1'b1);
    rsp_ready[0] = 1'b1;
    #1;
    check_eq("release_ready", 32'(req_ready[0]), 32'd1);
    accept;
    check_eq("b2b_valid", 32'(rsp_valid[0]), 32'd1);
    check_eq("b2b_idem", 32'(rsp_idem[0]), 32'd1);
    drain;

    // Counter: dual violation, saturation, clear priority
    drive_req(0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    drive_req(1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    accept;
    drain;
    send(0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive_req(0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      drive_req(1, 32'h9000_0000, 1'b1, 1'b1, 1'b0);
      accept;
      drain;
    end
    check_eq("sat_cnt", 32'(viol_cnt), 32'(CNT_SAT));
    drive_req(0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    exp_cnt = 0;
    accept;
    cnt_clr = 1'b0;
    drain;

`ifdef PMA_VIOLATION_LOG_EN
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    exp_cnt = 0;
    check_eq("log_clr_vld", 32'(log_vld), 32'd0);
    drive_req(1, 32'hDEAD_0000, 1'b0, 1'b1, 1'b0);
    drive_req(0, 32'hBEEF_0000, 1'b0, 1'b1, 1'b0);
    accept;
    check_eq("log_vld", 32'(log_vld), 32'd1);
    check_eq("log_addr", log_addr, 32'hBEEF_0000);
    check_eq("log_ch", 32'(log_ch), 32'd0);
    drain;
    send(1, 32'h1234_0000, 1'b0, 1'b1, 1'b0);
    check_eq("log_sticky_addr", log_addr, 32'hBEEF_0000);
    check_eq("log_sticky_ch", 32'(log_ch), 32'd0);
`endif

    check_eq("final_queues", 32'(q0.size() + q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
